// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: control inputs, cache read port and decode-side outputs.
// Signal suffixes are named from the fetch stage's point of view.
interface pc_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
);
  // Control from the pipeline
  logic              en_i;
  logic              stall_i;
  logic              branch_i;
  logic [ADDR_W-1:0] branch_off_i;
  logic              jump_i;
  logic [ADDR_W-1:0] jump_addr_i;

  // Instruction cache read port
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] rdaddr_o;

  // Decode side and status
  logic [INST_W-1:0] inst_o;
  logic              valid_o;
  logic [ADDR_W-1:0] pc_plus1_o;
  logic              wrap_o;
  logic              halted_o;
  logic [CNT_W-1:0]  retired_o;

  // The fetch stage itself
  modport master (
    input  en_i, stall_i, branch_i, branch_off_i, jump_i, jump_addr_i, inst_i,
    output rdaddr_o, inst_o, valid_o, pc_plus1_o, wrap_o, halted_o, retired_o
  );

  // Whatever surrounds it: control source, cache and decode
  modport slave (
    output en_i, stall_i, branch_i, branch_off_i, jump_i, jump_addr_i, inst_i,
    input  rdaddr_o, inst_o, valid_o, pc_plus1_o, wrap_o, halted_o, retired_o
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch control stage: owns the PC, addresses the instruction
// cache, qualifies the returned instruction for decode, detects the halt
// encoding and counts retired instructions.
module pc_fetch #(
  parameter int                ADDR_W    = 6,
  parameter int                INST_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [INST_W-1:0] HALT_INST = 32'hFFFF_FFFF,
  parameter int                CNT_W     = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  pc_fetch_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              wrap_q;
  logic [CNT_W-1:0]  retired_q;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_d;
  logic              seq_wrap_d;
  logic              is_halt;
  logic              valid;
  logic              retired_sat;

  // Issue qualification; the cache returns the instruction in the same cycle
  always_comb begin
    pc_plus1    = pc_q + ADDR_W'(1);
    is_halt     = (bus.inst_i == HALT_INST);
    valid       = (state_q == RUN) && !bus.stall_i && !is_halt;
    retired_sat = (retired_q == {CNT_W{1'b1}});
  end

  // Next-PC mux for an advancing RUN cycle: stall > jump > branch > step.
  // Only the sequential step can flag a wrap; branch/jump overflow is silent.
  always_comb begin
    pc_d       = pc_q;
    seq_wrap_d = 1'b0;
    if (bus.stall_i) begin
      pc_d = pc_q;
    end else if (bus.jump_i) begin
      pc_d = bus.jump_addr_i;
    end else if (bus.branch_i) begin
      // PC + 1 + sext(offset) modulo 2^ADDR_W is plain ADDR_W-bit addition
      pc_d = pc_plus1 + bus.branch_off_i;
    end else begin
      pc_d       = pc_plus1;
      seq_wrap_d = (pc_q == {ADDR_W{1'b1}});
    end
  end

  // Fetch FSM with the PC, wrap pulse and retired counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      wrap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (valid && !retired_sat) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.en_i) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (is_halt) begin
            // Halt wins over every control input; the PC stays on the halt word
            state_q <= HALT;
          end else if (!bus.en_i) begin
            state_q <= IDLE;
          end else begin
            pc_q   <= pc_d;
            wrap_q <= seq_wrap_d;
          end
        end
        HALT: begin
          // Sticky until reset
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdaddr_o   = pc_q;
  assign bus.pc_plus1_o = pc_plus1;
  assign bus.valid_o    = valid;
  assign bus.inst_o     = valid ? bus.inst_i : '0;
  assign bus.wrap_o     = wrap_q;
  assign bus.halted_o   = (state_q == HALT);
  assign bus.retired_o  = retired_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch. Each scenario task queues the expected
// observation as it drives stimulus and pops/compares once outputs settle.
module tb_pc_fetch;
  localparam int          AW   = 6;
  localparam int          IW   = 32;
  localparam int          CW   = 16;
  localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_1234;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pcp1;
    logic          valid;
    logic [IW-1:0] inst;
    logic          wrap;
    logic          halted;
    logic [CW-1:0] ret;
  } obs_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  obs_t exp_q[$];
  obs_t got;
  obs_t e;

  pc_fetch_if #(.ADDR_W(AW), .INST_W(IW), .CNT_W(CW)) bus ();

  pc_fetch #(
    .ADDR_W(AW), .INST_W(IW), .RESET_PC(6'd0), .HALT_INST(HLT), .CNT_W(CW)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t mk(input logic [AW-1:0] pc, input logic valid,
                              input logic [IW-1:0] inst, input logic wrap,
                              input logic halted, input logic [CW-1:0] ret);
    obs_t o;
    logic [AW-1:0] nxt;
    nxt      = pc + 6'd1;
    o.pc     = pc;
    o.pcp1   = nxt;
    o.valid  = valid;
    o.inst   = inst;
    o.wrap   = wrap;
    o.halted = halted;
    o.ret    = ret;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc     = bus.rdaddr_o;
    o.pcp1   = bus.pc_plus1_o;
    o.valid  = bus.valid_o;
    o.inst   = bus.inst_o;
    o.wrap   = bus.wrap_o;
    o.halted = bus.halted_o;
    o.ret    = bus.retired_o;
    return o;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) tick();
    exp_q.push_back(mk(6'd0, 1'b0, '0, 1'b0, 1'b0, 16'd0));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", got, e);
    end else $display("ok   reset pc=%0d ret=%0d", got.pc, got.ret);
    rst_ni = 1'b1;
    tick();
    exp_q.push_back(mk(6'd0, 1'b0, '0, 1'b0, 1'b0, 16'd0));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", got, e);
    end else $display("ok   reset_idle pc=%0d ret=%0d", got.pc, got.ret);
  endtask

  task automatic test_sequential();
    bus.en_i = 1'b1;
    exp_q.push_back(mk(6'd0, 1'b0, '0, 1'b0, 1'b0, 16'd0));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL seq_idle: got %h expected %h", got, e);
    end else $display("ok   seq_idle pc=%0d ret=%0d", got.pc, got.ret);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_q.push_back(mk(AW'(k), 1'b1, NOP, 1'b0, 1'b0, CW'(k)));
      #1;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL seq[%0d]: got %h expected %h", k, got, e);
      end else $display("ok   seq[%0d] pc=%0d ret=%0d", k, got.pc, got.ret);
    end
  endtask

  task automatic test_stall();
    repeat (2) tick();            // PC 3 -> 5
    bus.stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) bus.stall_i = 1'b0;
      case (k)
        0, 1:    exp_q.push_back(mk(6'd5, 1'b0, '0, 1'b0, 1'b0, 16'd5));
        2:       exp_q.push_back(mk(6'd5, 1'b1, NOP, 1'b0, 1'b0, 16'd5));
        default: exp_q.push_back(mk(6'd6, 1'b1, NOP, 1'b0, 1'b0, 16'd6));
      endcase
      #1;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %h expected %h", k, got, e);
      end else $display("ok   stall[%0d] pc=%0d ret=%0d", k, got.pc, got.ret);
      if (k < 3) tick();
    end
  endtask

  task automatic test_branch_jump();
    repeat (4) tick();            // PC 6 -> 10
    bus.branch_i     = 1'b1;
    bus.branch_off_i = 6'b111101;
    exp_q.push_back(mk(6'd10, 1'b1, NOP, 1'b0, 1'b0, 16'd10));
    exp_q.push_back(mk(6'd8,  1'b1, NOP, 1'b0, 1'b0, 16'd11));
    exp_q.push_back(mk(6'd20, 1'b1, NOP, 1'b0, 1'b0, 16'd12));
    for (int k = 0; k < 3; k++) begin
      #1;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL branch_jump[%0d]: got %h expected %h", k, got, e);
      end else $display("ok   branch_jump[%0d] pc=%0d ret=%0d", k, got.pc, got.ret);
      tick();
      if (k == 0) begin
        bus.jump_i      = 1'b1;
        bus.jump_addr_i = 6'd20;
      end else begin
        bus.jump_i   = 1'b0;
        bus.branch_i = 1'b0;
      end
    end
  endtask

  task automatic test_wrap();
    // Currently at PC 21, ret 13; jump to 62 first
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 6'd62;
    tick();
    bus.jump_i = 1'b0;
    exp_q.push_back(mk(6'd62, 1'b1, NOP, 1'b0, 1'b0, 16'd14));
    exp_q.push_back(mk(6'd63, 1'b1, NOP, 1'b0, 1'b0, 16'd15));
    exp_q.push_back(mk(6'd0,  1'b1, NOP, 1'b1, 1'b0, 16'd16));
    exp_q.push_back(mk(6'd1,  1'b1, NOP, 1'b0, 1'b0, 16'd17));
    for (int k = 0; k < 4; k++) begin
      #1;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL wrap_seq[%0d]: got %h expected %h", k, got, e);
      end else $display("ok   wrap_seq[%0d] pc=%0d wrap=%0b", k, got.pc, got.wrap);
      if (k < 3) tick();
    end
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 6'd60;
    tick();
    bus.jump_i       = 1'b0;
    bus.branch_i     = 1'b1;
    bus.branch_off_i = 6'd5;
    tick();
    bus.branch_i = 1'b0;
    exp_q.push_back(mk(6'd2, 1'b1, NOP, 1'b0, 1'b0, 16'd19));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL wrap_branch: got %h expected %h", got, e);
    end else $display("ok   wrap_branch pc=%0d wrap=%0b", got.pc, got.wrap);
  endtask

  task automatic test_enable_drop();
    bus.en_i = 1'b0;
    exp_q.push_back(mk(6'd2, 1'b1, NOP, 1'b0, 1'b0, 16'd19));
    exp_q.push_back(mk(6'd2, 1'b0, '0,  1'b0, 1'b0, 16'd20));
    exp_q.push_back(mk(6'd2, 1'b0, '0,  1'b0, 1'b0, 16'd20));
    for (int k = 0; k < 3; k++) begin
      #1;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL en_drop[%0d]: got %h expected %h", k, got, e);
      end else $display("ok   en_drop[%0d] pc=%0d ret=%0d", k, got.pc, got.ret);
      if (k < 2) tick();
    end
  endtask

  task automatic test_reset_mid_run();
    rst_ni = 1'b0;
    #1;
    rst_ni   = 1'b1;
    bus.en_i = 1'b1;
    tick();                       // IDLE -> RUN at PC 0
    repeat (30) tick();
    exp_q.push_back(mk(6'd30, 1'b1, NOP, 1'b0, 1'b0, 16'd30));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL pre_reset: got %h expected %h", got, e);
    end else $display("ok   pre_reset pc=%0d ret=%0d", got.pc, got.ret);
    #2;
    rst_ni = 1'b0;                // between edges, no clock follows before the check
    exp_q.push_back(mk(6'd0, 1'b0, '0, 1'b0, 1'b0, 16'd0));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", got, e);
    end else $display("ok   async_reset pc=%0d ret=%0d", got.pc, got.ret);
    bus.en_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    exp_q.push_back(mk(6'd0, 1'b0, '0, 1'b0, 1'b0, 16'd0));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h expected %h", got, e);
    end else $display("ok   post_reset_idle pc=%0d ret=%0d", got.pc, got.ret);
  endtask

  task automatic test_halt();
    bus.en_i = 1'b1;
    tick();                       // RUN at PC 0
    repeat (7) tick();
    bus.inst_i      = HLT;
    bus.stall_i     = 1'b1;
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 6'd33;
    exp_q.push_back(mk(6'd7, 1'b0, '0, 1'b0, 1'b0, 16'd7));
    #1;
    got = sample(); e = exp_q.pop_front(); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL halt_issue: got %h expected %h", got, e);
    end else $display("ok   halt_issue pc=%0d valid=%0b", got.pc, got.valid);
    bus.stall_i = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(mk(6'd7, 1'b0, '0, 1'b0, 1'b1, 16'd7));
      #1;
      got = sample(); e = exp_q.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL halted[%0d]: got %h expected %h", k, got, e);
      end else $display("ok   halted[%0d] pc=%0d ret=%0d", k, got.pc, got.ret);
      bus.en_i         = 1'($urandom_range(0, 1));
      bus.stall_i      = 1'($urandom_range(0, 1));
      bus.jump_i       = 1'($urandom_range(0, 1));
      bus.branch_i     = 1'($urandom_range(0, 1));
      bus.jump_addr_i  = 6'($urandom);
      bus.branch_off_i = 6'($urandom);
      bus.inst_i       = (k[0]) ? NOP : HLT;
      tick();
    end
  endtask

  initial begin
    bus.en_i         = 1'b0;
    bus.stall_i      = 1'b0;
    bus.branch_i     = 1'b0;
    bus.branch_off_i = '0;
    bus.jump_i       = 1'b0;
    bus.jump_addr_i  = '0;
    bus.inst_i       = NOP;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_jump();
    test_wrap();
    test_enable_drop();
    test_reset_mid_run();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
